load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MAX_WAIT, 16, cycles allowed between bus_req assertion and bus_ack before timeout.
REQ-002 Parameter DM_WORDS, 3072, number of addressable 32-bit words; byte addresses >= DM_WORDS*4 are out of range.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-low; 0 = reset.
REQ-005 op_valid  in  1  M-stage memory operation present.
REQ-006 op_write  in  1  1 = store, 0 = load.
REQ-007 op_type  in  3  store: 000 sw, 001 sb, 010 sh; load: 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu.
REQ-008 addr  in  32  byte address.
REQ-009 wdata  in  32  store data, right-aligned.
REQ-010 stall  out  1  freeze pipeline.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 err  out  1  valid with done; misaligned, out-of-range, illegal op_type, or timeout.
REQ-013 rdata  out  32  extended load result, valid with done.
REQ-014 bus_req  out  1  request to data memory.
REQ-015 bus_we  out  1  write strobe.
REQ-016 bus_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
REQ-017 bus_be  out  4  byte enables.
REQ-018 bus_wdata  out  32  lane-replicated store data.
REQ-019 bus_ack  in  1  memory accepted/completed request.
REQ-020 bus_rdata  in  32  full word, valid with bus_ack.

Function
REQ-021 FSM states SHALL be IDLE, REQ, DONE.
REQ-022 IDLE: op_valid with legal request -> REQ next edge; illegal request -> DONE with err=1, no bus activity.
REQ-023 REQ: bus_req=1 with bus_we/bus_addr/bus_be/bus_wdata registered and stable until bus_ack sampled 1 -> DONE.
REQ-024 REQ: wait counter reaching MAX_WAIT without bus_ack -> bus_req drops, DONE with err=1, rdata=0.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE unconditionally; a new op is accepted only from IDLE.
REQ-026 stall SHALL equal op_valid AND state != DONE (combinational); min latency op_valid->done = 2 cycles with same-cycle ack.
REQ-027 bus_be: word 1111; half addr[1]=0 -> 0011, 1 -> 1100; byte 0001 << addr[1:0]; loads use same enables.
REQ-028 bus_wdata: sw wdata; sh {2{wdata[15:0]}}; sb {4{wdata[7:0]}}.
REQ-029 Misaligned: word with addr[1:0]!=0, half with addr[0]!=0.
REQ-030 Load extraction from bus_rdata selected by addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend; stores give rdata=0.
REQ-031 rdata/err SHALL hold registered values captured at bus_ack until the next DONE.
REQ-032 bus_ack outside REQ SHALL be ignored.

Reset
REQ-033 reset=0 SHALL immediately force IDLE, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, done=0, err=0, rdata=0, counter=0, including mid-transaction.
REQ-034 First accepted op after reset release SHALL be on the first posedge with reset=1.

Structure
REQ-035 Shared package holds op_type encodings, FSM state encoding, byte-enable constants.
REQ-036 One sub-module, lsu_load_extend: combinational lane select and sign/zero extension.

Verification
REQ-037 sb addr=0x00000005 wdata=0x000000AB, ack after 1 cycle -> bus_be=0010, bus_wdata=0xABABABAB, bus_addr=0x4, done, err=0.
REQ-038 lh addr=0x2, bus_rdata=0x8001_1234 -> rdata=0xFFFF8001; lhu -> 0x00008001.
REQ-039 lw addr=0x6 -> no bus_req, done next cycle, err=1.
REQ-040 sw addr=0x3000 (DM_WORDS=3072) -> err=1, no bus_req.
REQ-041 bus_ack held 0 for 16 cycles -> bus_req drops, done, err=1, rdata=0; stall high throughout.
REQ-042 reset=0 asserted while in REQ -> bus_req=0 same cycle; post-release lb addr=0x3, bus_rdata=0x7F000000 -> rdata=0x0000007F.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: op_type codes, FSM states, byte enables.
// Latency: none (declarations and a pure decode function only).
// Backpressure: not applicable.
package load_store_unit_pkg;

  // Store op_type encodings (op_write = 1)
  localparam logic [2:0] ST_SW  = 3'b000;
  localparam logic [2:0] ST_SB  = 3'b001;
  localparam logic [2:0] ST_SH  = 3'b010;

  // Load op_type encodings (op_write = 0)
  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsuState_e;

  // SZ_NONE marks an op_type code that has no meaning for the given direction.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_NONE = 2'd3
  } accessSize_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  // Access width implied by direction and op_type.
  function automatic accessSize_e decodeSize(input logic isWrite, input logic [2:0] opType);
    accessSize_e sz;
    sz = SZ_NONE;
    if (isWrite) begin
      case (opType)
        ST_SW:   sz = SZ_WORD;
        ST_SB:   sz = SZ_BYTE;
        ST_SH:   sz = SZ_HALF;
        default: sz = SZ_NONE;
      endcase
    end else begin
      case (opType)
        LD_LW:          sz = SZ_WORD;
        LD_LB, LD_LBU:  sz = SZ_BYTE;
        LD_LH, LD_LHU:  sz = SZ_HALF;
        default:        sz = SZ_NONE;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Selects the addressed byte/halfword lane of a memory word and sign/zero extends it.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs.
module lsu_load_extend
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  opType,
  input  logic [1:0]  byteOff,
  input  logic [31:0] busWord,
  output logic [31:0] loadData
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Lane select by byte offset, then extension chosen by load flavour.
  always_comb begin
    byteSel  = busWord[{byteOff, 3'b000} +: 8];
    halfSel  = byteOff[1] ? busWord[31:16] : busWord[15:0];
    loadData = 32'h0;
    case (opType)
      LD_LW:   loadData = busWord;
      LD_LB:   loadData = {{24{byteSel[7]}}, byteSel};
      LD_LBU:  loadData = {24'h0, byteSel};
      LD_LH:   loadData = {{16{halfSel[15]}}, halfSel};
      LD_LHU:  loadData = {16'h0, halfSel};
      default: loadData = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// M-stage load/store unit: decodes one memory op, runs a single bus request, returns extended data.
// Latency: 2 cycles op_valid->done with same-cycle bus_ack; 1 cycle for an illegal op; MAX_WAIT+1 on timeout.
// Backpressure: stall holds the pipeline while an op is pending; bus side waits on bus_ack up to MAX_WAIT cycles.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int DM_WORDS = 3072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_write,
  input  logic [2:0]  op_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int          CW         = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);
  localparam logic [31:0] ADDR_LIMIT = 32'(DM_WORDS * 4);

  lsuState_e   state, stateNext;
  logic [CW-1:0] waitCnt;

  logic        busWeQ;
  logic [31:0] busAddrQ;
  logic [3:0]  busBeQ;
  logic [31:0] busWdataQ;
  logic [2:0]  opTypeQ;
  logic [1:0]  byteOffQ;
  logic        errQ;
  logic [31:0] rdataQ;

  accessSize_e accessSize;
  logic        misaligned;
  logic        outOfRange;
  logic        reqLegal;
  logic [3:0]  beNext;
  logic [31:0] wdataNext;
  logic        waitExpired;
  logic [31:0] loadResult;

  // Request decode: legality, byte enables and lane-replicated store data.
  always_comb begin
    accessSize = decodeSize(op_write, op_type);
    misaligned = 1'b0;
    beNext     = BE_NONE;
    wdataNext  = 32'h0;
    case (accessSize)
      SZ_WORD: begin
        misaligned = (addr[1:0] != 2'b00);
        beNext     = BE_WORD;
        wdataNext  = wdata;
      end
      SZ_HALF: begin
        misaligned = addr[0];
        beNext     = addr[1] ? BE_HALF_HI : BE_HALF_LO;
        wdataNext  = {2{wdata[15:0]}};
      end
      SZ_BYTE: begin
        beNext     = BE_BYTE0 << addr[1:0];
        wdataNext  = {4{wdata[7:0]}};
      end
      default: begin
        misaligned = 1'b0;
      end
    endcase
    outOfRange = (addr >= ADDR_LIMIT);
    reqLegal   = (accessSize != SZ_NONE) && !misaligned && !outOfRange;
  end

  assign waitExpired = (waitCnt == WAIT_LAST);

  lsu_load_extend uLoadExtend (
    .opType   (opTypeQ),
    .byteOff  (byteOffQ),
    .busWord  (bus_rdata),
    .loadData (loadResult)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state logic; bus_ack only matters while a request is outstanding.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (op_valid) stateNext = reqLegal ? REQ : DONE;
      end
      REQ: begin
        if (bus_ack || waitExpired) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Bus request registers, wait counter and captured result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waitCnt   <= '0;
      busWeQ    <= 1'b0;
      busAddrQ  <= 32'h0;
      busBeQ    <= BE_NONE;
      busWdataQ <= 32'h0;
      opTypeQ   <= 3'b000;
      byteOffQ  <= 2'b00;
      errQ      <= 1'b0;
      rdataQ    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid && reqLegal) begin
            waitCnt   <= '0;
            busWeQ    <= op_write;
            busAddrQ  <= {addr[31:2], 2'b00};
            busBeQ    <= beNext;
            busWdataQ <= wdataNext;
            opTypeQ   <= op_type;
            byteOffQ  <= addr[1:0];
          end else if (op_valid) begin
            errQ      <= 1'b1;
            rdataQ    <= 32'h0;
          end
        end
        REQ: begin
          if (bus_ack || waitExpired) begin
            // A completing ack wins over a simultaneous expiry.
            errQ      <= !bus_ack;
            rdataQ    <= (bus_ack && !busWeQ) ? loadResult : 32'h0;
            waitCnt   <= '0;
            busWeQ    <= 1'b0;
            busAddrQ  <= 32'h0;
            busBeQ    <= BE_NONE;
            busWdataQ <= 32'h0;
          end else begin
            waitCnt   <= waitCnt + 1'b1;
          end
        end
        default: begin
          waitCnt <= '0;
        end
      endcase
    end
  end

  assign stall     = op_valid && (state != DONE);
  assign done      = (state == DONE);
  assign err       = errQ;
  assign rdata     = rdataQ;
  assign bus_req   = (state == REQ);
  assign bus_we    = busWeQ;
  assign bus_addr  = busAddrQ;
  assign bus_be    = busBeQ;
  assign bus_wdata = busWdataQ;

endmodule
